// File: rtl/rgmii_tx_sequencer.sv
// rtl/rgmii_tx_sequencer.sv - RGMII transmit framer: preamble/SFD, data, underflow abort, IFG
// Byte stream in, DDR-register nibble pairs out; 1G DDR or 10/100 nibble-per-cycle SDR.
module rgmii_tx_sequencer #(
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       speed_1g,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       txctl_d1,
  output logic       txctl_d2,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DRAIN, IFG} state_t;

  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  state_t     state, state_n;
  logic       mode, mode_n;
  logic       phase, phase_n;
  logic [2:0] pre_cnt, pre_cnt_n;
  logic [7:0] ifg_cnt, ifg_cnt_n;
  logic [3:0] hold, hold_n;
  logic       hold_last, hold_last_n;
  logic       hold_err, hold_err_n;

  logic       em_mode;
  logic [7:0] em_byte;
  logic       em_en, em_er, em_under;
  logic [3:0] d1_n, d2_n, nib;

  always_comb begin
    s_ready = 1'b0;
    case (state)
      DATA:    s_ready = mode | ~phase;
      DRAIN:   s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    mode_n      = mode;
    phase_n     = phase;
    pre_cnt_n   = pre_cnt;
    ifg_cnt_n   = ifg_cnt;
    hold_n      = hold;
    hold_last_n = hold_last;
    hold_err_n  = hold_err;
    em_mode     = mode;
    em_byte     = 8'h00;
    em_en       = 1'b0;
    em_er       = 1'b0;
    em_under    = 1'b0;
    case (state)
      IDLE: begin
        // The start cycle already emits the first preamble byte-time so the
        // output gap between frames is exactly IFG_BYTES byte-times.
        if (s_valid) begin
          state_n   = PREAMBLE;
          mode_n    = speed_1g;
          em_mode   = speed_1g;
          em_byte   = 8'h55;
          em_en     = 1'b1;
          pre_cnt_n = speed_1g ? 3'd1 : 3'd0;
          phase_n   = ~speed_1g;
        end
      end
      PREAMBLE: begin
        em_en   = 1'b1;
        em_byte = (pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
        phase_n = mode ? 1'b0 : ~phase;
        if (mode || phase) begin
          if (pre_cnt == 3'd7) begin
            state_n   = DATA;
            pre_cnt_n = 3'd0;
          end else begin
            pre_cnt_n = pre_cnt + 3'd1;
          end
        end
      end
      DATA: begin
        em_en = 1'b1;
        if (mode) begin
          if (s_valid) begin
            em_byte = s_data;
            if (s_last) begin
              state_n   = IFG;
              ifg_cnt_n = 8'd0;
            end
          end else begin
            em_er    = 1'b1;
            em_under = 1'b1;
            state_n  = DRAIN;
          end
        end else if (!phase) begin
          phase_n = 1'b1;
          if (s_valid) begin
            em_byte     = s_data;
            hold_n      = s_data[7:4];
            hold_last_n = s_last;
            hold_err_n  = 1'b0;
          end else begin
            em_er       = 1'b1;
            em_under    = 1'b1;
            hold_n      = 4'h0;
            hold_last_n = 1'b0;
            hold_err_n  = 1'b1;
          end
        end else begin
          phase_n = 1'b0;
          em_er   = hold_err;
          em_byte = {hold, 4'h0};
          if (hold_err) begin
            state_n = DRAIN;
          end else if (hold_last) begin
            state_n   = IFG;
            ifg_cnt_n = 8'd0;
          end
        end
      end
      DRAIN: begin
        phase_n = 1'b0;
        if (s_valid && s_last) begin
          state_n   = IFG;
          ifg_cnt_n = 8'd0;
        end
      end
      IFG: begin
        phase_n = mode ? 1'b0 : ~phase;
        if (mode || phase) begin
          if (ifg_cnt == IFG_LAST) begin
            state_n   = IDLE;
            ifg_cnt_n = 8'd0;
          end else begin
            ifg_cnt_n = ifg_cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // 10/100 drives one nibble per cycle on both DDR halves.
  always_comb begin
    nib = phase ? em_byte[7:4] : em_byte[3:0];
    if (em_mode) begin
      d1_n = em_byte[3:0];
      d2_n = em_byte[7:4];
    end else begin
      d1_n = nib;
      d2_n = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      phase     <= 1'b0;
      pre_cnt   <= 3'd0;
      ifg_cnt   <= 8'd0;
      hold      <= 4'h0;
      hold_last <= 1'b0;
      hold_err  <= 1'b0;
      txd_d1    <= 4'h0;
      txd_d2    <= 4'h0;
      txctl_d1  <= 1'b0;
      txctl_d2  <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      phase     <= phase_n;
      pre_cnt   <= pre_cnt_n;
      ifg_cnt   <= ifg_cnt_n;
      hold      <= hold_n;
      hold_last <= hold_last_n;
      hold_err  <= hold_err_n;
      txd_d1    <= d1_n;
      txd_d2    <= d2_n;
      txctl_d1  <= em_en;
      txctl_d2  <= em_en ^ em_er;
      busy      <= (state_n != IDLE);
      underflow <= em_under;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_sequencer.sv
// tb/tb_rgmii_tx_sequencer.sv - directed self-checking bench for rgmii_tx_sequencer
module tb_rgmii_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       speed_1g;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [3:0] txd_d1, txd_d2;
  logic       txctl_d1, txctl_d2, busy, underflow;

  int errors = 0;
  int checks = 0;

  // {d1, d2, ctl1, ctl2, busy, underflow}
  logic [11:0] obs;
  assign obs = {txd_d1, txd_d2, txctl_d1, txctl_d2, busy, underflow};

  rgmii_tx_sequencer #(.IFG_BYTES(12)) dut (
    .clk(clk), .rst(rst), .speed_1g(speed_1g), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .txd_d1(txd_d1), .txd_d2(txd_d2),
    .txctl_d1(txctl_d1), .txctl_d2(txctl_d2), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; speed_1g = 1'b1; s_data = 8'h00; s_last = 1'b0;
    step();
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, 12'h000); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    rst = 1'b0; s_valid = 1'b0;
    step();
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL idle_outputs: got %h want %h", obs, 12'h000); end
  endtask

  task automatic test_frame_1g();
    logic [7:0] b [3];
    logic [11:0] exp;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    speed_1g = 1'b1; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp = {4'h5, (i == 7) ? 4'hD : 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL g1_pre[%0d]: got %h want %h", i, obs, exp); end
      checks++; if (s_ready !== (i == 7)) begin errors++; $display("FAIL g1_pre_ready[%0d]: got %b want %b", i, s_ready, i == 7); end
    end
    for (int i = 0; i < 3; i++) begin
      s_data = b[i]; s_last = (i == 2);
      step();
      exp = {b[i][3:0], b[i][7:4], 1'b1, 1'b1, 1'b1, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL g1_data[%0d]: got %h want %h", i, obs, exp); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {10'h000, (k < 12), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL g1_ifg[%0d]: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_frame_100();
    logic [11:0] exp;
    speed_1g = 1'b0; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp = {(i == 15) ? 4'hD : 4'h5, (i == 15) ? 4'hD : 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL fe_pre[%0d]: got %h want %h", i, obs, exp); end
    end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fe_ready_p0: got %b want 1", s_ready); end
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (obs !== {4'h5, 4'h5, 4'b1110}) begin errors++; $display("FAIL fe_lo: got %h want %h", obs, {4'h5, 4'h5, 4'b1110}); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fe_ready_p1: got %b want 0", s_ready); end
    step();
    checks++; if (obs !== {4'hA, 4'hA, 4'b1110}) begin errors++; $display("FAIL fe_hi: got %h want %h", obs, {4'hA, 4'hA, 4'b1110}); end
    for (int k = 1; k <= 24; k++) begin
      step();
      exp = {10'h000, (k < 24), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL fe_ifg[%0d]: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_underflow();
    logic [11:0] exp;
    speed_1g = 1'b1; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
    for (int i = 0; i < 8; i++) step();
    step();
    checks++; if (obs !== {4'h1, 4'h1, 4'b1110}) begin errors++; $display("FAIL uf_d0: got %h want %h", obs, {4'h1, 4'h1, 4'b1110}); end
    s_data = 8'h22;
    step();
    checks++; if (obs !== {4'h2, 4'h2, 4'b1110}) begin errors++; $display("FAIL uf_d1: got %h want %h", obs, {4'h2, 4'h2, 4'b1110}); end
    s_valid = 1'b0;
    step();
    checks++; if (obs !== {4'h0, 4'h0, 4'b1011}) begin errors++; $display("FAIL uf_err: got %h want %h", obs, {4'h0, 4'h0, 4'b1011}); end
    step();
    checks++; if (obs !== 12'h002) begin errors++; $display("FAIL uf_drain: got %h want %h", obs, 12'h002); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL uf_drain_ready: got %b want 1", s_ready); end
    s_valid = 1'b1; s_data = 8'h77;
    step();
    checks++; if (obs !== 12'h002 || s_ready !== 1'b1) begin errors++; $display("FAIL uf_discard: got %h/%b want %h/1", obs, s_ready, 12'h002); end
    s_last = 1'b1;
    step();
    checks++; if (obs !== 12'h002 || s_ready !== 1'b0) begin errors++; $display("FAIL uf_to_ifg: got %h/%b want %h/0", obs, s_ready, 12'h002); end
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {10'h000, (k < 12), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL uf_ifg[%0d]: got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_reset_mid();
    speed_1g = 1'b1; s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
    step(); step(); step();
    checks++; if (obs !== {4'h5, 4'h5, 4'b1110}) begin errors++; $display("FAIL rm_pre2: got %h want %h", obs, {4'h5, 4'h5, 4'b1110}); end
    rst = 1'b1;
    step();
    checks++; if (obs !== 12'h000 || s_ready !== 1'b0) begin errors++; $display("FAIL rm_abort: got %h/%b want 000/0", obs, s_ready); end
    rst = 1'b0;
    step();
    checks++; if (obs !== {4'h5, 4'h5, 4'b1110}) begin errors++; $display("FAIL rm_restart: got %h want %h", obs, {4'h5, 4'h5, 4'b1110}); end
    do_reset();
  endtask

  task automatic test_speed_change();
    logic [11:0] exp;
    speed_1g = 1'b0; s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b1;
    for (int i = 0; i < 16; i++) step();
    speed_1g = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (obs !== {4'hC, 4'hC, 4'b1110}) begin errors++; $display("FAIL sc_lo: got %h want %h", obs, {4'hC, 4'hC, 4'b1110}); end
    step();
    checks++; if (obs !== {4'h3, 4'h3, 4'b1110}) begin errors++; $display("FAIL sc_hi: got %h want %h", obs, {4'h3, 4'h3, 4'b1110}); end
    for (int k = 1; k <= 24; k++) begin
      step();
      exp = {10'h000, (k < 24), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL sc_ifg[%0d]: got %h want %h", k, obs, exp); end
    end
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp = {4'h5, (i == 7) ? 4'hD : 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL sc_new_pre[%0d]: got %h want %h", i, obs, exp); end
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    speed_1g = 1'b1; s_valid = 1'b1; s_data = 8'h42; s_last = 1'b1;
    for (int i = 0; i < 8; i++) step();
    step();
    checks++; if (obs !== {4'h2, 4'h4, 4'b1110}) begin errors++; $display("FAIL bb_data: got %h want %h", obs, {4'h2, 4'h4, 4'b1110}); end
    s_data = 8'h99; s_last = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {10'h000, (k < 12), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL bb_gap[%0d]: got %h want %h", k, obs, exp); end
    end
    step();
    checks++; if (obs !== {4'h5, 4'h5, 4'b1110}) begin errors++; $display("FAIL bb_next_pre: got %h want %h", obs, {4'h5, 4'h5, 4'b1110}); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1; speed_1g = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    step(); step();
    test_reset();
    test_frame_1g();
    test_frame_100();
    test_underflow();
    test_reset_mid();
    test_speed_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
